// File: rtl/mr_issue_ctl.sv
// Issue controller between decode and the ALU: scoreboard hazard stall, branch serialisation, taken-branch flush.
// Optional MR_ISSUE_WB_BYPASS_EN lets the hazard check see this cycle's writeback clear.
module mr_issue_ctl #(
  parameter int REGSEL_BITS = 5,
  parameter int FLUSH_CYC   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [REGSEL_BITS-1:0]    dec_rs1,
  input  logic [REGSEL_BITS-1:0]    dec_rs2,
  input  logic                      dec_use_rs1,
  input  logic                      dec_use_rs2,
  input  logic [REGSEL_BITS-1:0]    dec_rd,
  input  logic                      dec_is_br,
  output logic                      id_valid,
  input  logic                      id_ready,
  input  logic                      wb_valid,
  input  logic [REGSEL_BITS-1:0]    wb_reg,
  input  logic                      jmp_done,
  input  logic                      wb_pc_valid,
  output logic                      flush,
  output logic                      hazard,
  output logic [2**REGSEL_BITS-1:0] busy_mask
);

  localparam int NREGS = 2**REGSEL_BITS;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_t;

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [NREGS-1:0] busy, busy_eff, wb_clr, rd_set;
  logic             hazard_raw, fire;

  always_comb begin
    wb_clr = '0;
    rd_set = '0;
    if (wb_valid && wb_reg != '0) wb_clr[wb_reg] = 1'b1;
    if (fire && dec_rd != '0)     rd_set[dec_rd] = 1'b1;
  end

`ifdef MR_ISSUE_WB_BYPASS_EN
  assign busy_eff = busy & ~wb_clr;
`else
  assign busy_eff = busy;
`endif

  assign hazard_raw = dec_valid & ((dec_use_rs1 & busy_eff[dec_rs1]) |
                                   (dec_use_rs2 & busy_eff[dec_rs2]) |
                                   ((dec_rd != '0) & busy_eff[dec_rd]));

  assign hazard    = !rst & hazard_raw;
  assign id_valid  = !rst & dec_valid & (state == RUN) & !hazard_raw;
  assign dec_ready = id_valid & id_ready;
  assign fire      = dec_ready;
  assign busy_mask = busy;

  // A taken branch flushes in its resolve cycle, so FLUSH itself lasts FLUSH_CYC-1 cycles.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    flush    = 1'b0;
    case (state)
      RUN: begin
        if (fire && dec_is_br) state_nx = BR_WAIT;
      end
      BR_WAIT: begin
        if (jmp_done) begin
          if (wb_pc_valid) begin
            flush    = 1'b1;
            cnt_nx   = FLUSH_LOAD;
            state_nx = (FLUSH_CYC > 1) ? FLUSH : RUN;
          end else begin
            state_nx = RUN;
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (cnt <= 4'd1) state_nx = RUN;
        if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
      end
      default: state_nx = RUN;
    endcase
    if (rst) flush = 1'b0;
  end

  // Set wins over a same-register writeback clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
      busy  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (busy & ~wb_clr) | rd_set;
    end
  end

endmodule

// File: tb/tb_mr_issue_ctl.sv
// Randomized self-checking bench for mr_issue_ctl against a behavioural issue/scoreboard model.
// Honors MR_ISSUE_WB_BYPASS_EN the same way as the design.
module tb_mr_issue_ctl;

  localparam int RB    = 5;
  localparam int NREGS = 2**RB;
  localparam int FC    = 2;

  logic            clk = 1'b0;
  logic            rst, dec_valid, dec_ready, dec_use_rs1, dec_use_rs2, dec_is_br;
  logic [RB-1:0]   dec_rs1, dec_rs2, dec_rd, wb_reg;
  logic            id_valid, id_ready, wb_valid, jmp_done, wb_pc_valid, flush, hazard;
  logic [NREGS-1:0] busy_mask;

  int checks = 0;
  int errors = 0;

  // Model state: which registers are in flight, whether a branch is unresolved,
  // and how many flush cycles are still owed.
  bit m_busy[NREGS];
  bit br_pending;
  int flush_left;
  bit hold;

  bit e_rdy, e_idv, e_hz, e_flush;
  logic [NREGS-1:0] e_mask;

  mr_issue_ctl #(.REGSEL_BITS(RB), .FLUSH_CYC(FC)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .dec_rd(dec_rd), .dec_is_br(dec_is_br),
    .id_valid(id_valid), .id_ready(id_ready), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .jmp_done(jmp_done), .wb_pc_valid(wb_pc_valid),
    .flush(flush), .hazard(hazard), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Small register range (0..7) keeps hazards and set/clear collisions frequent.
  task automatic applyStimulus(input bit force_rst);
    rst = force_rst || ($urandom_range(99) < 2);
    if (!hold) begin
      dec_valid   = ($urandom_range(99) < 75);
      dec_rs1     = RB'($urandom_range(7));
      dec_rs2     = RB'($urandom_range(7));
      dec_use_rs1 = $urandom_range(1) == 1;
      dec_use_rs2 = $urandom_range(1) == 1;
      dec_rd      = RB'($urandom_range(7));
      dec_is_br   = ($urandom_range(99) < 15);
    end
    id_ready    = ($urandom_range(99) < 75);
    wb_valid    = ($urandom_range(99) < 50);
    wb_reg      = RB'($urandom_range(7));
    jmp_done    = ($urandom_range(99) < 35);
    wb_pc_valid = $urandom_range(1) == 1;
  endtask

  function automatic bit effBusy(input int r);
    bit b;
    b = m_busy[r];
`ifdef MR_ISSUE_WB_BYPASS_EN
    if (wb_valid && int'(wb_reg) == r && r != 0) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic computeExpected();
    bit can_issue;
    can_issue = !br_pending && (flush_left == 0);
    e_hz = dec_valid && ((dec_use_rs1 && effBusy(int'(dec_rs1))) ||
                         (dec_use_rs2 && effBusy(int'(dec_rs2))) ||
                         (dec_rd != 0 && effBusy(int'(dec_rd))));
    e_idv   = dec_valid && can_issue && !e_hz;
    e_rdy   = e_idv && id_ready;
    e_flush = (flush_left > 0) || (br_pending && jmp_done && wb_pc_valid);
    if (rst) begin
      e_hz = 0; e_idv = 0; e_rdy = 0; e_flush = 0;
    end
    for (int i = 0; i < NREGS; i++) e_mask[i] = m_busy[i];
  endtask

  task automatic advanceModel();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
      br_pending = 0;
      flush_left = 0;
      hold = 0;
      return;
    end
    hold = dec_valid && !e_rdy && !e_flush;
    if (wb_valid && wb_reg != 0) m_busy[wb_reg] = 0;
    if (e_rdy && dec_rd != 0) m_busy[dec_rd] = 1;
    if (flush_left > 0) flush_left--;
    if (br_pending && jmp_done) begin
      br_pending = 0;
      if (wb_pc_valid) flush_left = FC - 1;
    end
    if (e_rdy && dec_is_br) br_pending = 1;
  endtask

  initial begin
    hold = 0;
    br_pending = 0;
    flush_left = 0;
    for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      applyStimulus(cyc < 2);
      #1;
      computeExpected();
      checkOutput("dec_ready", 64'(dec_ready), 64'(e_rdy));
      checkOutput("id_valid",  64'(id_valid),  64'(e_idv));
      checkOutput("hazard",    64'(hazard),    64'(e_hz));
      checkOutput("flush",     64'(flush),     64'(e_flush));
      if (cyc > 0) checkOutput("busy_mask", 64'(busy_mask), 64'(e_mask));
      advanceModel();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
